// File: rtl/cache_victim_select_if.sv
// Miss/victim handshake bundle between the cache controller and cache_victim_select.
// master = requester side (drives miss/fill inputs), slave = the selector.
interface cache_victim_select_if #(
    parameter int NUMWAYS = 4
);
    logic               FlushStage;
    logic               MissReq;
    logic [NUMWAYS-1:0] ValidWay;
    logic [NUMWAYS-1:0] LFSRVictimWay;
    logic               FillDone;
    logic [NUMWAYS-1:0] VictimWay;
    logic               VictimValid;
    logic               VictimEvict;
    logic               LFSRWriteEn;
    logic               Busy;

    modport master (
        output FlushStage, MissReq, ValidWay, LFSRVictimWay, FillDone,
        input  VictimWay, VictimValid, VictimEvict, LFSRWriteEn, Busy
    );

    modport slave (
        input  FlushStage, MissReq, ValidWay, LFSRVictimWay, FillDone,
        output VictimWay, VictimValid, VictimEvict, LFSRWriteEn, Busy
    );
endinterface

// File: rtl/cache_victim_select.sv
// Victim-way selector and fill sequencer (IDLE/SELECT/FILL/DONE).
// Build option: define VICTIM_INVALID_FIRST_EN to prefer the lowest invalid way over the LFSR way.

// One way of a lowest-set-bit priority chain.
module cache_victim_select_lane (
    input  logic i_bit,
    input  logic i_below,
    output logic o_pick,
    output logic o_any
);
    assign o_pick = i_bit & ~i_below;
    assign o_any  = i_bit | i_below;
endmodule

module cache_victim_select #(
    parameter int NUMWAYS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    cache_victim_select_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_FILL, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUMWAYS-1:0] r_victim_way;
    logic               r_victim_evict;

    logic [NUMWAYS-1:0] w_lfsr_pick;
    logic [NUMWAYS:0]   w_lfsr_any;
    logic [NUMWAYS-1:0] w_lfsr_vic;
    logic [NUMWAYS-1:0] w_victim;
    logic               w_evict;
    logic               w_load;

    // Sanitise the LFSR way: keep the lowest set bit, fall back to way 0 when empty.
    assign w_lfsr_any[0] = 1'b0;
    cache_victim_select_lane u_lfsr_lane [NUMWAYS-1:0] (
        .i_bit   (bus.LFSRVictimWay),
        .i_below (w_lfsr_any[NUMWAYS-1:0]),
        .o_pick  (w_lfsr_pick),
        .o_any   (w_lfsr_any[NUMWAYS:1])
    );
    assign w_lfsr_vic = w_lfsr_any[NUMWAYS] ? w_lfsr_pick : NUMWAYS'(1);

`ifdef VICTIM_INVALID_FIRST_EN
    logic [NUMWAYS-1:0] w_inv_pick;
    logic [NUMWAYS:0]   w_inv_any;

    assign w_inv_any[0] = 1'b0;
    cache_victim_select_lane u_inv_lane [NUMWAYS-1:0] (
        .i_bit   (~bus.ValidWay),
        .i_below (w_inv_any[NUMWAYS-1:0]),
        .o_pick  (w_inv_pick),
        .o_any   (w_inv_any[NUMWAYS:1])
    );
    // Any invalid way avoids an eviction entirely.
    assign w_victim = w_inv_any[NUMWAYS] ? w_inv_pick : w_lfsr_vic;
    assign w_evict  = ~w_inv_any[NUMWAYS];
`else
    assign w_victim = w_lfsr_vic;
    assign w_evict  = |(bus.ValidWay & w_lfsr_vic);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE:   if (bus.MissReq && !bus.FlushStage) w_state_nxt = S_SELECT;
            S_SELECT: begin
                if (bus.FlushStage) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_FILL;
                    w_load      = 1'b1;
                end
            end
            // A fill completing under flush is already committed, so it still advances the LFSR.
            S_FILL: begin
                if (bus.FillDone)        w_state_nxt = S_DONE;
                else if (bus.FlushStage) w_state_nxt = S_IDLE;
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_victim_way   <= '0;
            r_victim_evict <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_victim_way   <= w_victim;
                r_victim_evict <= w_evict;
            end
        end
    end

    assign bus.VictimWay   = r_victim_way;
    assign bus.VictimEvict = r_victim_evict;
    assign bus.VictimValid = (r_state == S_FILL);
    assign bus.LFSRWriteEn = (r_state == S_DONE);
    assign bus.Busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_cache_victim_select.sv
// Self-checking bench for cache_victim_select: directed literal cases plus randomized traffic vs a reference model.
module tb_cache_victim_select;
    localparam int NW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cache_victim_select_if #(.NUMWAYS(NW)) bus ();

    cache_victim_select #(.NUMWAYS(NW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference victim choice from the rules: first set LFSR bit (way 0 if none), first clear valid bit.
    function automatic int first_set(input logic [NW-1:0] l);
        for (int i = 0; i < NW; i++) if (l[i]) return i;
        return 0;
    endfunction

    function automatic logic [NW-1:0] ref_victim(input logic [NW-1:0] v, input logic [NW-1:0] l);
        logic [NW-1:0] one;
        one = 1;
`ifdef VICTIM_INVALID_FIRST_EN
        for (int i = 0; i < NW; i++) if (!v[i]) return one << i;
`endif
        return one << first_set(l);
    endfunction

    function automatic logic ref_evict(input logic [NW-1:0] v, input logic [NW-1:0] l);
`ifdef VICTIM_INVALID_FIRST_EN
        return (v == {NW{1'b1}});
`else
        return v[first_set(l)];
`endif
    endfunction

    // Model: position within the miss sequence (0 idle, 1 select, 2 fill, 3 done).
    int            m_pos;
    logic [NW-1:0] m_vic;
    logic          m_ev;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pos <= 0;
            m_vic <= '0;
            m_ev  <= 1'b0;
        end else if (m_pos == 0) begin
            if (bus.MissReq && !bus.FlushStage) m_pos <= 1;
        end else if (m_pos == 1) begin
            if (bus.FlushStage) m_pos <= 0;
            else begin
                m_pos <= 2;
                m_vic <= ref_victim(bus.ValidWay, bus.LFSRVictimWay);
                m_ev  <= ref_evict(bus.ValidWay, bus.LFSRVictimWay);
            end
        end else if (m_pos == 2) begin
            if (bus.FillDone)        m_pos <= 3;
            else if (bus.FlushStage) m_pos <= 0;
        end else begin
            m_pos <= 0;
        end
    end

    logic prev_we = 1'b0;
    always @(negedge clock) begin
        chk("VictimWay",   bus.VictimWay,   m_vic);
        chk("VictimEvict", bus.VictimEvict, m_ev);
        chk("VictimValid", bus.VictimValid, m_pos == 2);
        chk("LFSRWriteEn", bus.LFSRWriteEn, m_pos == 3);
        chk("Busy",        bus.Busy,        m_pos != 0);
        if (prev_we) chk("we_consecutive", bus.LFSRWriteEn, 1'b0);
        prev_we = bus.LFSRWriteEn;
    end

    // Miss in IDLE, FillDone 3 cycles later; checks victim, pulse timing and return to IDLE.
    task automatic miss_fill(input string nm, input logic [NW-1:0] v, input logic [NW-1:0] l,
                             input logic [NW-1:0] exp_vic, input logic exp_ev);
        bus.MissReq = 1'b1; bus.ValidWay = v; bus.LFSRVictimWay = l;
        tick();
        bus.MissReq = 1'b0;
        chk({nm, "_sel_busy"}, bus.Busy, 1'b1);
        chk({nm, "_sel_valid"}, bus.VictimValid, 1'b0);
        tick();
        chk({nm, "_vic"}, bus.VictimWay, exp_vic);
        chk({nm, "_evict"}, bus.VictimEvict, exp_ev);
        chk({nm, "_valid"}, bus.VictimValid, 1'b1);
        tick();
        bus.FillDone = 1'b1;
        chk({nm, "_we_early"}, bus.LFSRWriteEn, 1'b0);
        tick();
        bus.FillDone = 1'b0;
        chk({nm, "_we"}, bus.LFSRWriteEn, 1'b1);
        chk({nm, "_vic_hold"}, bus.VictimWay, exp_vic);
        tick();
        chk({nm, "_we_off"}, bus.LFSRWriteEn, 1'b0);
        chk({nm, "_idle"}, bus.Busy, 1'b0);
    endtask

    initial begin
        bus.FlushStage = 1'b0; bus.MissReq = 1'b0; bus.FillDone = 1'b0;
        bus.ValidWay = '0; bus.LFSRVictimWay = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_vic", bus.VictimWay, 4'b0000);
        chk("rst_busy", bus.Busy, 1'b0);
        chk("rst_we", bus.LFSRWriteEn, 1'b0);
        reset = 1'b0;
        tick();

`ifdef VICTIM_INVALID_FIRST_EN
        miss_fill("inv_first", 4'b1011, 4'b0001, 4'b0100, 1'b0);
`else
        miss_fill("lfsr_only", 4'b1011, 4'b1000, 4'b1000, 1'b1);
`endif
        miss_fill("all_valid", 4'b1111, 4'b1000, 4'b1000, 1'b1);
        miss_fill("multi_hot", 4'b1111, 4'b0110, 4'b0010, 1'b1);
        miss_fill("zero_lfsr", 4'b1111, 4'b0000, 4'b0001, 1'b1);

        // Flush in SELECT: victim keeps 4'b0001 from the previous miss.
        bus.MissReq = 1'b1; bus.ValidWay = 4'b1111; bus.LFSRVictimWay = 4'b0100;
        tick();
        bus.MissReq = 1'b0; bus.FlushStage = 1'b1;
        tick();
        bus.FlushStage = 1'b0;
        chk("flsel_busy", bus.Busy, 1'b0);
        chk("flsel_valid", bus.VictimValid, 1'b0);
        chk("flsel_vic", bus.VictimWay, 4'b0001);
        tick();
        chk("flsel_we", bus.LFSRWriteEn, 1'b0);

        // Flush in FILL without FillDone.
        bus.MissReq = 1'b1;
        tick();
        bus.MissReq = 1'b0;
        tick();
        bus.FlushStage = 1'b1;
        tick();
        bus.FlushStage = 1'b0;
        chk("flfill_busy", bus.Busy, 1'b0);
        chk("flfill_we", bus.LFSRWriteEn, 1'b0);
        tick();
        chk("flfill_we2", bus.LFSRWriteEn, 1'b0);

        // Flush together with FillDone still commits.
        bus.MissReq = 1'b1;
        tick();
        bus.MissReq = 1'b0;
        tick();
        bus.FlushStage = 1'b1; bus.FillDone = 1'b1;
        tick();
        bus.FlushStage = 1'b0; bus.FillDone = 1'b0;
        chk("flfd_we", bus.LFSRWriteEn, 1'b1);
        tick();

        // Reset mid-FILL clears everything immediately.
        bus.MissReq = 1'b1;
        tick();
        bus.MissReq = 1'b0;
        tick();
        chk("rstf_infill", bus.VictimValid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rstf_vic", bus.VictimWay, 4'b0000);
        chk("rstf_valid", bus.VictimValid, 1'b0);
        chk("rstf_busy", bus.Busy, 1'b0);
        chk("rstf_evict", bus.VictimEvict, 1'b0);
        bus.FillDone = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstf_no_we", bus.LFSRWriteEn, 1'b0);
        end
        bus.FillDone = 1'b0;

        // Back-to-back misses: one pulse every 4 cycles, Busy low one cycle between.
        bus.MissReq = 1'b1; bus.FillDone = 1'b1; bus.ValidWay = 4'b0111;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("b2b_we", bus.LFSRWriteEn, (k % 4) == 3);
            chk("b2b_busy", bus.Busy, (k % 4) != 0);
        end
        bus.MissReq = 1'b0; bus.FillDone = 1'b0;
        tick();

        // Randomized traffic, checked by the per-cycle compare process.
        for (int k = 0; k < 3000; k++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            bus.MissReq    = ($urandom_range(0, 1) == 1);
            bus.FlushStage = ($urandom_range(0, 7) == 0);
            bus.FillDone   = ($urandom_range(0, 2) == 0);
            bus.ValidWay   = ($urandom_range(0, 1) == 1) ? 4'b1111 : NW'($urandom);
            if ($urandom_range(0, 3) == 0) bus.LFSRVictimWay = NW'($urandom);
            else                           bus.LFSRVictimWay = NW'(1) << $urandom_range(0, NW - 1);
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_victim_select.md
# cache_victim_select

Victim-way selection and fill sequencer for the set-associative cache, sitting directly downstream of the cache LFSR replacement block. On a miss it registers a one-hot victim way: the lowest-index invalid way if one exists, otherwise the LFSR's pseudo-random way. It holds that way stable for the fill, and on fill completion pulses `LFSRWriteEn` to advance the LFSR. A pipeline flush aborts a pending selection or fill without advancing the LFSR.

## Interface
- `NUMWAYS`, default 4: number of ways; a power of two, ≥ 2.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `FlushStage`  in  1  abort the current miss handling.
- `MissReq`  in  1  cache miss; a victim is needed.
- `ValidWay`  in  NUMWAYS  valid bits of the addressed set.
- `LFSRVictimWay`  in  NUMWAYS  one-hot pseudo-random victim from the cache LFSR.
- `FillDone`  in  1  the fill of `VictimWay` is written this cycle.
- `VictimWay`  out  NUMWAYS  registered one-hot victim way.
- `VictimValid`  out  1  `VictimWay` is stable and usable for the fill.
- `VictimEvict`  out  1  the chosen way was valid at selection, so a writeback/evict check is required.
- `LFSRWriteEn`  out  1  one-cycle pulse that advances the LFSR.
- `Busy`  out  1  state ≠ IDLE.

## Operation
- The FSM has four states: IDLE, SELECT, FILL and DONE.
  - **IDLE:** `MissReq & ~FlushStage` → SELECT; otherwise stay in IDLE.
  - **SELECT:**
    - Computes the victim combinationally from `ValidWay`/`LFSRVictimWay` sampled this cycle.
    - On the edge, registers `VictimWay` and `VictimEvict`, then → FILL.
    - `FlushStage` → IDLE, and `VictimWay`/`VictimEvict` are not updated.
  - **FILL:** `VictimValid` = 1.
    - `FillDone` → DONE.
    - `FlushStage & ~FillDone` → IDLE.
    - `FillDone & FlushStage` → DONE (the fill is already committed).
    - Otherwise stay in FILL.
  - **DONE:** `LFSRWriteEn` = 1, then → IDLE unconditionally.
    - `FlushStage` has no effect.
    - `MissReq` is ignored; the requester re-presents it in IDLE.
- Victim choice when invalid-first is enabled (see Configuration):
  - If `ValidWay` ≠ all-ones, the victim is the one-hot of the lowest-index zero bit of `ValidWay`, and `VictimEvict` = 0.
  - Otherwise the victim is the one-hot `LFSRVictimWay`, and `VictimEvict` = 1.
- `LFSRVictimWay` sanitising:
  - A multi-hot value keeps only its lowest set bit.
  - An all-zero value selects way 0.
  - `VictimWay` is therefore always exactly one-hot after the first selection.
- `VictimWay` and `VictimEvict` hold their last value outside SELECT edges.
- `Busy` = (state ≠ IDLE).
- `VictimValid` = (state == FILL).
- `LFSRWriteEn` = (state == DONE).
- All outputs are decoded from the state register, so no input-to-output combinational path exists.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE;
  - `VictimWay` = 0, `VictimEvict` = 0, `VictimValid` = 0, `LFSRWriteEn` = 0, `Busy` = 0.
- Reset asserted mid-operation aborts it immediately, with no `LFSRWriteEn` pulse.
- Latency, with `MissReq` high in IDLE in cycle n:
  - cycle n+1 is SELECT;
  - `VictimValid` is high from cycle n+2.
- `FillDone` in cycle m (in FILL) gives `LFSRWriteEn` high in cycle m+1, then IDLE in m+2.
- The minimum miss-to-miss spacing is 4 cycles (IDLE, SELECT, FILL, DONE).
- `FillDone` outside FILL is ignored.
- `LFSRWriteEn` is never asserted for two consecutive cycles.

## Configuration
- **`VICTIM_INVALID_FIRST_EN` defined:** the invalid-way priority described in Operation applies.
- **Undefined:**
  - The victim is always the sanitised `LFSRVictimWay`, regardless of `ValidWay`.
  - `VictimEvict` = `|(ValidWay & victim)`.
  - All FSM and timing behaviour is identical in both builds.

## Test plan
- **Reset mid-FILL:** with NUMWAYS=4, reach FILL, then assert `reset` → in the same cycle all outputs are 0 and the state is IDLE; no `LFSRWriteEn` appears afterwards.
- **Invalid way preferred (macro defined):**
  - Stimulus: `ValidWay`=4'b1011, `LFSRVictimWay`=4'b0001, `MissReq` for 1 cycle, `FillDone` 3 cycles later.
  - Response: `VictimWay`=4'b0100 and `VictimEvict`=0 from cycle n+2; `LFSRWriteEn` pulses exactly once, the cycle after `FillDone`.
- **All ways valid:**
  - Stimulus: `ValidWay`=4'b1111, `LFSRVictimWay`=4'b1000.
  - Response: `VictimWay`=4'b1000 and `VictimEvict`=1.
  - With the macro undefined and `ValidWay`=4'b1011, the same LFSR value gives `VictimWay`=4'b1000 and `VictimEvict`=1.
- **Flush abort:**
  - Flush in SELECT → IDLE; `VictimWay` keeps its prior value; `VictimValid` is never asserted; no `LFSRWriteEn`.
  - Flush in FILL without `FillDone` → IDLE with no `LFSRWriteEn`.
  - `FlushStage`+`FillDone` together in FILL → `LFSRWriteEn` pulses.
- **Malformed LFSR input:**
  - `ValidWay`=4'b1111 with `LFSRVictimWay`=4'b0110 → `VictimWay`=4'b0010.
  - `ValidWay`=4'b1111 with `LFSRVictimWay`=4'b0000 → `VictimWay`=4'b0001.
- **Back-to-back misses:**
  - Stimulus: `MissReq` held high continuously, `FillDone` asserted each time in FILL.
  - Response: one `LFSRWriteEn` pulse every 4 cycles; `MissReq` in DONE is not accepted early; `Busy` is low for exactly 1 cycle between misses.
